// File: rtl/imm_ext_stage.sv
// Immediate-extension stage for the decode -> execute boundary: opcode-driven
// extension into a DATA_W operand, held in a valid/ready register with a one-entry skid buffer.
module imm_ext_stage #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [5:0]        in_opcode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [1:0]        out_mode,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic [1:0] {
    MODE_SEXT = 2'd0,
    MODE_ZEXT = 2'd1,
    MODE_LUI  = 2'd2,
    MODE_BR   = 2'd3
  } mode_e;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  // Input-side decode and extension
  mode_e             new_mode;
  logic [DATA_W-1:0] sext_val;
  logic [DATA_W-1:0] zext_val;
  logic [DATA_W-1:0] new_imm;

  always_comb begin
    new_mode = MODE_SEXT;
    case (in_opcode)
      OP_ANDI, OP_ORI, OP_XORI: new_mode = MODE_ZEXT;
      OP_LUI:                   new_mode = MODE_LUI;
      OP_BEQ, OP_BNE:           new_mode = MODE_BR;
      default:                  new_mode = MODE_SEXT;
    endcase
  end

  // LUI and BR are built by shifting the extended values, which avoids a
  // zero-width replication when DATA_W == IMM_W + 2.
  always_comb begin
    sext_val = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    zext_val = {{(DATA_W-IMM_W){1'b0}}, in_imm};
    new_imm  = sext_val;
    case (new_mode)
      MODE_SEXT: new_imm = sext_val;
      MODE_ZEXT: new_imm = zext_val;
      MODE_LUI:  new_imm = zext_val << (DATA_W - IMM_W);
      MODE_BR:   new_imm = sext_val << 2;
      default:   new_imm = sext_val;
    endcase
  end

  // Main (M) and skid (S) registers
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_imm_q,   m_imm_d;
  mode_e             m_mode_q,  m_mode_d;
  logic [TAG_W-1:0]  m_tag_q,   m_tag_d;

  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_imm_q,   s_imm_d;
  mode_e             s_mode_q,  s_mode_d;
  logic [TAG_W-1:0]  s_tag_q,   s_tag_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_imm_d   = m_imm_q;
    m_mode_d  = m_mode_q;
    m_tag_d   = m_tag_q;
    s_valid_d = s_valid_q;
    s_imm_d   = s_imm_q;
    s_mode_d  = s_mode_q;
    s_tag_d   = s_tag_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_fire) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_imm_d   = s_imm_q;
        m_mode_d  = s_mode_q;
        m_tag_d   = s_tag_q;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_imm_d   = new_imm;
        m_mode_d  = new_mode;
        m_tag_d   = in_tag;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_imm_d   = new_imm;
      s_mode_d  = new_mode;
      s_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_imm_q   <= '0;
      m_mode_q  <= MODE_SEXT;
      m_tag_q   <= '0;
      s_valid_q <= 1'b0;
      s_imm_q   <= '0;
      s_mode_q  <= MODE_SEXT;
      s_tag_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_imm_q   <= m_imm_d;
      m_mode_q  <= m_mode_d;
      m_tag_q   <= m_tag_d;
      s_valid_q <= s_valid_d;
      s_imm_q   <= s_imm_d;
      s_mode_q  <= s_mode_d;
      s_tag_q   <= s_tag_d;
    end
  end

  // in_ready comes straight from the skid flop, so out_ready never reaches it.
  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign out_imm   = m_imm_q;
  assign out_mode  = m_mode_q;
  assign out_tag   = m_tag_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: vector table for extension modes, plus
// hand-written stall, flush and reset-in-stall sequences.
module tb_imm_ext_stage;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  logic [5:0]        in_opcode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic [1:0]        out_mode;
  logic [TAG_W-1:0]  out_tag;

  imm_ext_stage #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_opcode(in_opcode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_mode(out_mode), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [15:0] imm;
    logic [31:0] exp_imm;
    logic [1:0]  exp_mode;
  } vec_t;

  vec_t vecs[12];

  logic [TAG_W-1:0]  out_tags[$];
  logic [DATA_W-1:0] out_imms[$];
  int acc_cnt;

  // Record handshakes with stable inputs/outputs, then advance one edge.
  task automatic step();
    if (out_valid && out_ready) begin
      out_tags.push_back(out_tag);
      out_imms.push_back(out_imm);
    end
    if (in_valid && in_ready) acc_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int next_tag;
    logic acc;

    vecs[0]  = '{6'b001000, 16'hFFF0, 32'hFFFF_FFF0, 2'd0}; // ADDI
    vecs[1]  = '{6'b001101, 16'h8001, 32'h0000_8001, 2'd1}; // ORI
    vecs[2]  = '{6'b001111, 16'h1234, 32'h1234_0000, 2'd2}; // LUI
    vecs[3]  = '{6'b000100, 16'hFFFF, 32'hFFFF_FFFC, 2'd3}; // BEQ
    vecs[4]  = '{6'b001100, 16'hFFFF, 32'h0000_FFFF, 2'd1}; // ANDI
    vecs[5]  = '{6'b001110, 16'h7FFF, 32'h0000_7FFF, 2'd1}; // XORI
    vecs[6]  = '{6'b000101, 16'h0001, 32'h0000_0004, 2'd3}; // BNE
    vecs[7]  = '{6'b100011, 16'h8000, 32'hFFFF_8000, 2'd0}; // LW
    vecs[8]  = '{6'b001111, 16'hFFFF, 32'hFFFF_0000, 2'd2}; // LUI
    vecs[9]  = '{6'b000101, 16'h8000, 32'hFFFE_0000, 2'd3}; // BNE
    vecs[10] = '{6'b000000, 16'h7FFF, 32'h0000_7FFF, 2'd0}; // R-type
    vecs[11] = '{6'b001011, 16'h8000, 32'hFFFF_8000, 2'd0}; // SLTIU

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0;
    in_opcode = '0; in_tag = '0; out_ready = 1'b0; acc_cnt = 0;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_imm",   out_imm, 0);
    check("rst_out_mode",  out_mode, 0);
    check("rst_out_tag",   out_tag, 0);
    check("rst_in_ready",  in_ready, 1);
    rst = 1'b0;
    step();

    // Back-to-back vectors with out_ready=1: each appears one edge later.
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_opcode = vecs[i].op;
      in_imm    = vecs[i].imm;
      in_tag    = TAG_W'(i);
      step();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_imm", i),   out_imm, vecs[i].exp_imm);
      check($sformatf("vec%0d_mode", i),  out_mode, vecs[i].exp_mode);
      check($sformatf("vec%0d_tag", i),   out_tag, 64'(i));
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("drain_out_valid", out_valid, 0);

    // Stall: tags 1..4 offered continuously, out_ready low for 3 cycles.
    out_tags.delete(); out_imms.delete(); acc_cnt = 0; next_tag = 1;
    for (int cyc = 0; cyc < 30 && out_tags.size() < 4; cyc++) begin
      in_valid  = (next_tag <= 4);
      in_tag    = TAG_W'(next_tag);
      in_opcode = 6'b001101;
      in_imm    = 16'(16'h1111 * next_tag);
      out_ready = (cyc >= 3);
      if (cyc == 1) check("stall_in_ready_c1", in_ready, 1);
      if (cyc == 2) begin
        check("stall_in_ready_c2", in_ready, 0);
        check("stall_accepted_c2", acc_cnt, 2);
      end
      if (cyc == 3) begin
        check("stall_head_valid", out_valid, 1);
        check("stall_head_tag", out_tag, 1);
      end
      acc = in_valid && in_ready;
      step();
      if (acc) next_tag++;
    end
    in_valid = 1'b0;
    check("stall_out_count", out_tags.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < out_tags.size()) begin
        check($sformatf("stall_order_tag%0d", k), out_tags[k], 64'(k + 1));
        check($sformatf("stall_order_imm%0d", k), out_imms[k], 64'(16'h1111 * (k + 1)));
      end
    end

    // Flush with M and S full; offered input in the flush cycle is dropped.
    out_ready = 1'b0; in_opcode = 6'b001000; in_imm = '0;
    in_valid = 1'b1; in_tag = 5'd10; step();
    in_tag = 5'd11; step();
    check("flushA_full_in_ready", in_ready, 0);
    check("flushA_full_out_valid", out_valid, 1);
    flush = 1'b1; in_tag = 5'd12; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flushA_out_valid", out_valid, 0);
    check("flushA_in_ready", in_ready, 1);
    out_ready = 1'b1; out_tags.delete();
    repeat (3) step();
    check("flushA_nothing_out", out_tags.size(), 0);

    // Flush with only M full, in_ready=1: the offered entry must not be taken.
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd13; step();
    flush = 1'b1; in_tag = 5'd14; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flushB_out_valid", out_valid, 0);
    check("flushB_in_ready", in_ready, 1);
    out_ready = 1'b1; out_tags.delete();
    repeat (3) step();
    check("flushB_nothing_out", out_tags.size(), 0);
    in_valid = 1'b1; in_tag = 5'd15; in_imm = 16'h0005; step();
    in_valid = 1'b0;
    check("post_flush_valid", out_valid, 1);
    check("post_flush_tag", out_tag, 15);
    check("post_flush_imm", out_imm, 32'h0000_0005);

    // Reset mid-stall with flush and in_valid also asserted.
    out_ready = 1'b0; in_opcode = 6'b001111; in_imm = 16'h1234;
    in_valid = 1'b1; in_tag = 5'd20; step();
    in_tag = 5'd21; step();
    check("rststall_full_in_ready", in_ready, 0);
    rst = 1'b1; flush = 1'b1; in_tag = 5'd22; in_imm = 16'hFFFF; in_opcode = 6'b000100;
    step();
    check("rststall_out_valid", out_valid, 0);
    check("rststall_out_imm", out_imm, 0);
    check("rststall_out_mode", out_mode, 0);
    check("rststall_out_tag", out_tag, 0);
    check("rststall_in_ready", in_ready, 1);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("rststall_after_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
